pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Next-PC controller for the 8-bit program counter register. Each cycle it takes the current PC and the decoded control-flow operation and produces `next_pc`, which the PC register loads on the following rising edge. It supports sequential fetch, conditional relative branch, absolute jump, and call/return through an internal return-address stack. It also provides stall, halt/resume, and flush signalling for the fetch stage.

## Interface
- `STACK_DEPTH`, 4: return-address stack entries (2..8).
- `RESET_VECTOR`, 8'h00: first PC issued after reset.
- `clock`  in  1  rising-edge clock, shared with the PC register.
- `clear_n`  in  1  reset, asynchronous, active-low; the PC register's active-high clear is driven from `~clear_n` at top level.
- `ppc`  in  8  current PC from the PC register.
- `op`  in  3  control op: 0 SEQ, 1 BRZ, 2 JMP, 3 CALL, 4 RET, 5 HALT; 6/7 are treated as SEQ.
- `zero`  in  1  ALU zero flag; qualifies BRZ.
- `target`  in  8  absolute address for JMP/CALL; signed two's-complement offset for BRZ.
- `stall`  in  1  hold the PC this cycle.
- `resume`  in  1  leave HALT.
- `next_pc`  out  8  value the PC register loads at the next edge.
- `flush`  out  1  one-cycle pulse after a taken redirect.
- `halted`  out  1  high while in HALT.
- `depth`  out  3  number of valid stack entries.
- `err_overflow`  out  1  sticky flag: CALL issued with the stack full.
- `err_underflow`  out  1  sticky flag: RET issued with the stack empty.

## Operation
- FSM states: BOOT, RUN, HALT. `clear_n` low forces BOOT asynchronously.
- Reset values: state BOOT, `depth` 0, stack contents 0, `flush` 0, `halted` 0, both error flags 0.
- BOOT: `next_pc`=RESET_VECTOR; `op`/`stall` ignored; next state RUN.
- RUN, priority from highest:
  - `stall`: `next_pc`=`ppc`, no stack or state change, no flush.
  - SEQ: `next_pc`=`ppc`+1.
  - BRZ with `zero`=1: `next_pc`=`ppc`+1+sext(`target`), taken. BRZ with `zero`=0: treated as SEQ.
  - JMP: `next_pc`=`target`, taken.
  - CALL: push `ppc`+1, `depth`+1, `next_pc`=`target`, taken.
  - CALL with `depth`==STACK_DEPTH: no push, set `err_overflow`, `next_pc`=`ppc`+1, not taken.
  - RET: pop, `next_pc`=top entry, `depth`-1, taken.
  - RET with `depth`==0: set `err_underflow`, `next_pc`=`ppc`+1, not taken.
  - HALT: `next_pc`=`ppc`, next state HALT.
- HALT:
  - `next_pc`=`ppc`; `op` and `stall` are ignored.
  - `resume`=1: `next_pc`=`ppc`+1 (skips the HALT instruction), next state RUN.
  - `halted`=1 whenever the registered state is HALT.
- Arithmetic: all PC math is 8-bit modulo 256. 8'hFF+1 = 8'h00. Branch sums wrap, with no error.
- Stack: LIFO register array plus a `depth` counter. Push and pop happen on the clock edge. The top entry is read combinationally.
- The error flags clear only on reset.

## Timing
- `next_pc` is combinational from `ppc`, `op`, `zero`, `target`, `stall`, `resume` and the registered state. It must settle within one cycle. There is no latency between op presentation and the `next_pc` value.
- The PC register takes on `next_pc` at the first rising edge after it is presented.
- `flush` is registered. It is high for exactly the one cycle following an edge at which a taken redirect was loaded. Back-to-back taken ops give back-to-back `flush` cycles.
- The stack, `depth` and error flags update on the same edge as the PC load. `depth` is visible the next cycle.
- If `clear_n` is asserted mid-operation, all state returns to reset values immediately, independent of `clock`. The first cycle after release is BOOT.
- `clear_n` release is assumed synchronous to `clock` at top level. No reset synchronizer is inside the block.

## Test plan
- Reset/boot: hold `clear_n`=0, release, `op`=SEQ → first `next_pc`=8'h00, then 01, 02, 03; `flush`=0, `depth`=0.
- Branch and wrap:
  - `ppc`=8'h10, BRZ, `zero`=1, `target`=8'hFC → `next_pc`=8'h0D, `flush`=1 next cycle.
  - Same with `zero`=0 → 8'h11, no flush.
  - `ppc`=8'hFF, SEQ → 8'h00.
- Call/return nesting: CALL at `ppc`=8'h20 → `target` 8'h80, then CALL at 8'h80 → 8'hA0 → `depth`=2. RET → 8'h81, then RET → 8'h21, `depth`=0.
- Stack limits:
  - 5 CALLs with STACK_DEPTH=4 → 5th gives `next_pc`=`ppc`+1, `err_overflow`=1 sticky, `depth`=4.
  - RET with `depth`=0 → `err_underflow`=1.
- Stall/halt:
  - `stall`=1 during a JMP → `next_pc`=`ppc`, no flush.
  - HALT at 8'h30 → `next_pc` held at 8'h30, `halted`=1.
  - `resume` → 8'h31, `halted`=0.
- Async reset mid-call: drop `clear_n` between clock edges with `depth`=3 and `err_overflow`=1 → all outputs reset immediately; after release `next_pc`=RESET_VECTOR.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Signal bundle between the decode/PC-register side and the next-PC sequencer.
// The master presents the current PC and decoded op; the slave returns next_pc and status.
interface pc_sequencer_if;
   logic [7:0] ppc;
   logic [2:0] op;
   logic       zero;
   logic [7:0] target;
   logic       stall;
   logic       resume;
   logic [7:0] next_pc;
   logic       flush;
   logic       halted;
   logic [2:0] depth;
   logic       err_overflow;
   logic       err_underflow;

   modport master (
      output ppc, op, zero, target, stall, resume,
      input  next_pc, flush, halted, depth, err_overflow, err_underflow
   );

   modport slave (
      input  ppc, op, zero, target, stall, resume,
      output next_pc, flush, halted, depth, err_overflow, err_underflow
   );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: sequential fetch, relative branch, jump, call/return via a
// return-address stack, plus stall, halt/resume and a registered flush pulse.
module pc_sequencer #(
   parameter int         STACK_DEPTH  = 4,
   parameter logic [7:0] RESET_VECTOR = 8'h00
) (
   input logic           clock,
   input logic           clear_n,
   pc_sequencer_if.slave bus
);

   localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam logic [2:0] OP_SEQ  = 3'd0;
   localparam logic [2:0] OP_BRZ  = 3'd1;
   localparam logic [2:0] OP_JMP  = 3'd2;
   localparam logic [2:0] OP_CALL = 3'd3;
   localparam logic [2:0] OP_RET  = 3'd4;
   localparam logic [2:0] OP_HALT = 3'd5;

   logic [1:0]    state, state_nxt;
   logic [3:0]    cnt;
   logic [7:0]    stack [STACK_DEPTH];
   logic [IW-1:0] top_idx, push_idx;
   logic [7:0]    pc_inc, next_pc_c;
   logic          taken, push, pop, set_ovf, set_unf;
   logic          flush_q, ovf_q, unf_q;
   logic          stack_full, stack_empty;

   assign pc_inc      = bus.ppc + 8'd1;
   assign stack_full  = (cnt == 4'(STACK_DEPTH));
   assign stack_empty = (cnt == 4'd0);
   assign top_idx     = stack_empty ? '0 : IW'(cnt - 4'd1);
   assign push_idx    = IW'(cnt);

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves one unassigned, which would otherwise infer a latch.
      next_pc_c = pc_inc;
      state_nxt = state;
      taken     = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      set_ovf   = 1'b0;
      set_unf   = 1'b0;
      case (state)
         ST_BOOT: begin
            next_pc_c = RESET_VECTOR;
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (bus.stall) begin
               next_pc_c = bus.ppc;
            end else begin
               case (bus.op)
                  OP_BRZ: begin
                     // 8-bit modulo add of the raw offset equals adding its sign extension.
                     if (bus.zero) begin
                        next_pc_c = pc_inc + bus.target;
                        taken     = 1'b1;
                     end
                  end
                  OP_JMP: begin
                     next_pc_c = bus.target;
                     taken     = 1'b1;
                  end
                  OP_CALL: begin
                     if (stack_full) begin
                        set_ovf = 1'b1;
                     end else begin
                        push      = 1'b1;
                        next_pc_c = bus.target;
                        taken     = 1'b1;
                     end
                  end
                  OP_RET: begin
                     if (stack_empty) begin
                        set_unf = 1'b1;
                     end else begin
                        pop       = 1'b1;
                        next_pc_c = stack[top_idx];
                        taken     = 1'b1;
                     end
                  end
                  OP_HALT: begin
                     next_pc_c = bus.ppc;
                     state_nxt = ST_HALT;
                  end
                  default: next_pc_c = pc_inc;
               endcase
            end
         end
         ST_HALT: begin
            if (bus.resume) begin
               state_nxt = ST_RUN;
            end else begin
               next_pc_c = bus.ppc;
            end
         end
         default: begin
            next_pc_c = RESET_VECTOR;
            state_nxt = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!clear_n) begin
         state   <= ST_BOOT;
         cnt     <= 4'd0;
         flush_q <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         flush_q <= taken;
         if (push)      cnt <= cnt + 4'd1;
         else if (pop)  cnt <= cnt - 4'd1;
         if (set_ovf)   ovf_q <= 1'b1;
         if (set_unf)   unf_q <= 1'b1;
      end
   end

   // NOTE: the stack array is reset because its contents are defined as zero
   // after reset; a plain RAM without reset would not meet that.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= 8'h00;
      end else if (push) begin
         stack[push_idx] <= pc_inc;
      end
   end

   assign bus.next_pc       = next_pc_c;
   assign bus.flush         = flush_q;
   assign bus.halted        = (state == ST_HALT);
   // The 3-bit depth output saturates at 7 when built with eight entries.
   assign bus.depth         = (cnt > 4'd7) ? 3'd7 : cnt[2:0];
   assign bus.err_overflow  = ovf_q;
   assign bus.err_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected next_pc values go through a scoreboard
// queue; registered status outputs are checked just after the clock edge.
module tb_pc_sequencer;

   localparam logic [2:0] SEQ = 3'd0, BRZ = 3'd1, JMP = 3'd2, CALL = 3'd3, RET = 3'd4, HLT = 3'd5;

   typedef struct {
      string      tag;
      logic [7:0] pc;
   } exp_t;

   logic clock;
   logic clear_n;
   int   total;
   int   bad;
   exp_t sb[$];

   pc_sequencer_if bus ();

   pc_sequencer #(.STACK_DEPTH(4), .RESET_VECTOR(8'h00)) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one op at the falling edge, push the expected next_pc, then pop and compare.
   task automatic step(input string tag, input logic [2:0] op, input logic [7:0] ppc,
                       input logic [7:0] target, input logic zero, input logic stall,
                       input logic resume, input logic [7:0] exp_pc);
      exp_t e;
      @(negedge clock);
      bus.op     = op;
      bus.ppc    = ppc;
      bus.target = target;
      bus.zero   = zero;
      bus.stall  = stall;
      bus.resume = resume;
      sb.push_back('{tag, exp_pc});
      #1;
      e = sb.pop_front();
      chk(e.tag, bus.next_pc, e.pc);
   endtask

   task automatic post_edge();
      @(posedge clock);
      #1;
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      clear_n    = 1'b0;
      bus.op     = SEQ;
      bus.ppc    = 8'h00;
      bus.target = 8'h00;
      bus.zero   = 1'b0;
      bus.stall  = 1'b0;
      bus.resume = 1'b0;

      // Reset state
      #12;
      chk("rst_next_pc", bus.next_pc, 8'h00);
      chk("rst_flush", 8'(bus.flush), 8'h0);
      chk("rst_halted", 8'(bus.halted), 8'h0);
      chk("rst_depth", 8'(bus.depth), 8'h0);
      chk("rst_ovf", 8'(bus.err_overflow), 8'h0);
      chk("rst_unf", 8'(bus.err_underflow), 8'h0);
      post_edge();
      clear_n = 1'b1;

      // Boot then sequential fetch
      step("boot",  SEQ, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      step("seq01", SEQ, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01);
      step("seq02", SEQ, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02);
      step("seq03", SEQ, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 8'h03);
      post_edge();
      chk("seq_flush", 8'(bus.flush), 8'h0);
      chk("seq_depth", 8'(bus.depth), 8'h0);

      // Branch taken / not taken / wrap
      step("brz_taken", BRZ, 8'h10, 8'hFC, 1'b1, 1'b0, 1'b0, 8'h0D);
      post_edge();
      chk("brz_taken_flush", 8'(bus.flush), 8'h1);
      step("brz_not", BRZ, 8'h10, 8'hFC, 1'b0, 1'b0, 1'b0, 8'h11);
      post_edge();
      chk("brz_not_flush", 8'(bus.flush), 8'h0);
      step("brz_wrap", BRZ, 8'hF0, 8'h20, 1'b1, 1'b0, 1'b0, 8'h11);
      step("seq_wrap", SEQ, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      step("op7_seq", 3'd7, 8'h44, 8'h99, 1'b1, 1'b0, 1'b0, 8'h45);
      step("jmp", JMP, 8'h12, 8'hC3, 1'b0, 1'b0, 1'b0, 8'hC3);
      post_edge();
      chk("jmp_flush", 8'(bus.flush), 8'h1);

      // Nested call/return
      step("call1", CALL, 8'h20, 8'h80, 1'b0, 1'b0, 1'b0, 8'h80);
      step("call2", CALL, 8'h80, 8'hA0, 1'b0, 1'b0, 1'b0, 8'hA0);
      post_edge();
      chk("call2_depth", 8'(bus.depth), 8'h2);
      chk("call2_flush", 8'(bus.flush), 8'h1);
      step("ret1", RET, 8'hA0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h81);
      step("ret2", RET, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 8'h21);
      post_edge();
      chk("ret2_depth", 8'(bus.depth), 8'h0);

      // Overflow on the fifth call
      step("ovf_c1", CALL, 8'h40, 8'h50, 1'b0, 1'b0, 1'b0, 8'h50);
      step("ovf_c2", CALL, 8'h50, 8'h60, 1'b0, 1'b0, 1'b0, 8'h60);
      step("ovf_c3", CALL, 8'h60, 8'h70, 1'b0, 1'b0, 1'b0, 8'h70);
      step("ovf_c4", CALL, 8'h70, 8'h80, 1'b0, 1'b0, 1'b0, 8'h80);
      post_edge();
      chk("full_depth", 8'(bus.depth), 8'h4);
      chk("full_no_ovf", 8'(bus.err_overflow), 8'h0);
      step("ovf_c5", CALL, 8'h80, 8'h90, 1'b0, 1'b0, 1'b0, 8'h81);
      post_edge();
      chk("ovf_flag", 8'(bus.err_overflow), 8'h1);
      chk("ovf_depth", 8'(bus.depth), 8'h4);
      chk("ovf_flush", 8'(bus.flush), 8'h0);

      // Drain, then underflow
      step("drain1", RET, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 8'h71);
      step("drain2", RET, 8'h71, 8'h00, 1'b0, 1'b0, 1'b0, 8'h61);
      step("drain3", RET, 8'h61, 8'h00, 1'b0, 1'b0, 1'b0, 8'h51);
      step("drain4", RET, 8'h51, 8'h00, 1'b0, 1'b0, 1'b0, 8'h41);
      step("unf_ret", RET, 8'h42, 8'h00, 1'b0, 1'b0, 1'b0, 8'h43);
      post_edge();
      chk("unf_flag", 8'(bus.err_underflow), 8'h1);
      chk("unf_depth", 8'(bus.depth), 8'h0);
      chk("unf_flush", 8'(bus.flush), 8'h0);
      chk("ovf_sticky", 8'(bus.err_overflow), 8'h1);

      // Stall over a jump
      step("stall_jmp", JMP, 8'h55, 8'h99, 1'b0, 1'b1, 1'b0, 8'h55);
      post_edge();
      chk("stall_flush", 8'(bus.flush), 8'h0);

      // Halt and resume
      step("halt", HLT, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 8'h30);
      post_edge();
      chk("halt_halted", 8'(bus.halted), 8'h1);
      step("halt_hold", JMP, 8'h30, 8'h77, 1'b0, 1'b0, 1'b0, 8'h30);
      post_edge();
      chk("halt_still", 8'(bus.halted), 8'h1);
      chk("halt_flush", 8'(bus.flush), 8'h0);
      step("resume", SEQ, 8'h30, 8'h00, 1'b0, 1'b0, 1'b1, 8'h31);
      post_edge();
      chk("resume_halted", 8'(bus.halted), 8'h0);
      step("after_resume", SEQ, 8'h31, 8'h00, 1'b0, 1'b0, 1'b0, 8'h32);

      // Asynchronous reset with three frames live and overflow set
      step("rc1", CALL, 8'h01, 8'h10, 1'b0, 1'b0, 1'b0, 8'h10);
      step("rc2", CALL, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 8'h20);
      step("rc3", CALL, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0, 8'h30);
      post_edge();
      chk("pre_rst_depth", 8'(bus.depth), 8'h3);
      chk("pre_rst_flush", 8'(bus.flush), 8'h1);
      chk("pre_rst_ovf", 8'(bus.err_overflow), 8'h1);
      #2;
      clear_n = 1'b0;
      #1;
      chk("arst_depth", 8'(bus.depth), 8'h0);
      chk("arst_flush", 8'(bus.flush), 8'h0);
      chk("arst_ovf", 8'(bus.err_overflow), 8'h0);
      chk("arst_unf", 8'(bus.err_underflow), 8'h0);
      chk("arst_next_pc", bus.next_pc, 8'h00);
      post_edge();
      clear_n = 1'b1;
      step("reboot", CALL, 8'h30, 8'hEE, 1'b0, 1'b0, 1'b0, 8'h00);
      step("reboot_seq", SEQ, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01);
      post_edge();
      chk("reboot_depth", 8'(bus.depth), 8'h0);

      chk("sb_empty", 8'(sb.size()), 8'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
